// File: rtl/ysyx_23060278_dmem.sv
//============================================================================
// Module  : ysyx_23060278_dmem
// Brief   : Fixed-latency data memory with byte-lane stores and shifted loads.
//           Optional access checking is enabled by YSYX_23060278_DMEM_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module ysyx_23060278_dmem #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int c_idx_w = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_len;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  // Storage is deliberately outside the reset domain.
  logic [31:0] r_mem [DEPTH_WORDS];

  logic               w_hs;
  logic               w_fire;
  logic               w_rsp_done;
  logic [31:0]        w_off;
  logic [c_idx_w-1:0] w_idx;
  logic [1:0]         w_lane;
  logic [3:0]         w_len_mask;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_sh;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_rdata;
  logic               w_err;
  logic               w_we;
  logic               w_unused;

  assign req_ready  = (r_state == ST_IDLE);
  assign w_hs       = req_valid & req_ready;
  assign w_fire     = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;

  assign w_off    = r_addr - ADDR_BASE;
  assign w_idx    = w_off[c_idx_w+1:2];
  assign w_lane   = r_addr[1:0];
  assign w_unused = &{1'b0, w_off[31:c_idx_w+2], w_off[1:0]};

  always_comb begin
    w_len_mask = 4'b0000;
    case (r_len)
      4'd1:    w_len_mask = 4'b0001;
      4'd2:    w_len_mask = 4'b0011;
      4'd4:    w_len_mask = 4'b1111;
      default: w_len_mask = 4'b0000;
    endcase
  end

  // Shifting in a 4-bit / 32-bit context drops lanes above 3.
  assign w_be       = w_len_mask << w_lane;
  assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
  assign w_rd_word  = r_mem[w_idx];
  assign w_rdata    = w_rd_word >> {w_lane, 3'b000};

`ifdef YSYX_23060278_DMEM_ALIGN_CHECK_EN
  localparam logic [32:0] c_addr_end = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  logic w_oob;
  logic w_misalign;

  assign w_oob      = (r_addr < ADDR_BASE) || ({1'b0, r_addr} >= c_addr_end);
  assign w_misalign = r_wen && (((r_len == 4'd2) && r_addr[0]) ||
                                ((r_len == 4'd4) && (r_addr[1:0] != 2'b00)));
  assign w_err      = w_oob | w_misalign;
`else
  assign w_err      = 1'b0;
`endif

  assign w_we = w_fire & r_wen & ~w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_hs)       w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_fire)     w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_wen       <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_len       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_len   <= req_len;
        r_cnt   <= 4'(LATENCY - 1);
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_fire) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || r_wen) ? 32'd0 : w_rdata;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // A store commits only at the access edge, so a reset while busy leaves memory intact.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060278_dmem.sv
//============================================================================
// Module  : tb_ysyx_23060278_dmem
// Brief   : Directed scoreboard bench for ysyx_23060278_dmem.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ysyx_23060278_dmem;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mb [int unsigned];
  int         tests = 0;
  int         fails = 0;

  ysyx_23060278_dmem #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_len  (req_len),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic wen, input logic [31:0] addr, input logic [3:0] len);
`ifdef YSYX_23060278_DMEM_ALIGN_CHECK_EN
    longint a = longint'(addr);
    longint b = longint'(BASE);
    logic oob = (a < b) || (a >= b + 4 * DEPTH);
    logic mis = wen && ((len == 4'd2 && addr[0]) || (len == 4'd4 && addr[1:0] != 2'b00));
    return oob | mis;
`else
    return 1'b0 & wen & addr[0] & len[0];
`endif
  endfunction

  // Byte-level reference: update model on stores, predict data on loads.
  task automatic predict(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] len);
    exp_t        e;
    int unsigned w;
    int          o;
    w = ((addr - BASE) >> 2) % DEPTH;
    o = int'(addr[1:0]);
    e.err   = model_err(wen, addr, len);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (wen) begin
        if (len == 4'd1 || len == 4'd2 || len == 4'd4)
          for (int k = 0; k < int'(len); k++)
            if (o + k < 4) mb[w*4 + o + k] = wdata[8*k +: 8];
      end else begin
        for (int k = 0; k < 4; k++)
          if (o + k < 4) e.rdata[8*k +: 8] = mb[w*4 + o + k];
      end
    end
    q.push_back(e);
  endtask

  task automatic transact(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] len, input int hold);
    exp_t e;
    int   n;
    predict(wen, addr, wdata, len);
    @(negedge clk);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_len = len; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 n++;
      if (rsp_valid) break;
    end
    check({tag, ".latency"}, 32'(n), 32'(LAT));
    e = q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      // A competing store is offered while the response is stalled.
      req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'hBADB_ADBA;
      req_len = 4'd4; req_valid = 1'b1;
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, e.rdata);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, ".rdata"}, rsp_rdata, e.rdata);
    check({tag, ".err"}, 32'(rsp_err), 32'(e.err));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_len = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst.req_ready", 32'(req_ready), 32'd1);

    transact("st_word",  1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'd4, 0);
    transact("ld_word",  1'b0, 32'h8000_0010, 32'd0,         4'd0, 0);
    transact("st_byte",  1'b1, 32'h8000_0012, 32'h0000_005A, 4'd1, 0);
    transact("ld_mix",   1'b0, 32'h8000_0010, 32'd0,         4'd4, 0);
    transact("ld_off3",  1'b0, 32'h8000_0013, 32'd0,         4'd0, 0);
    transact("ld_stall", 1'b0, 32'h8000_0010, 32'd0,         4'd0, 5);
    transact("ld_after", 1'b0, 32'h8000_0010, 32'd0,         4'd0, 0);
    transact("st_half",  1'b1, 32'h8000_0011, 32'h0000_1234, 4'd2, 0);
    transact("ld_off1",  1'b0, 32'h8000_0011, 32'd0,         4'd0, 0);
    transact("st_len3",  1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'd3, 0);
    transact("st_len0",  1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'd0, 0);
    transact("ld_nowr",  1'b0, 32'h8000_0010, 32'd0,         4'd0, 0);
    transact("st_h_o3",  1'b1, 32'h8000_0013, 32'h0000_AABB, 4'd2, 0);
    transact("ld_h_o3",  1'b0, 32'h8000_0010, 32'd0,         4'd0, 0);
    transact("st_w0",    1'b1, 32'h8000_0000, 32'h0102_0304, 4'd4, 0);
    transact("st_mis",   1'b1, 32'h8000_0002, 32'hCAFE_BABE, 4'd4, 0);
    transact("ld_w0",    1'b0, 32'h8000_0000, 32'd0,         4'd0, 0);
    transact("st_top",   1'b1, 32'h8000_0FFC, 32'h5566_7788, 4'd4, 0);
    transact("ld_below", 1'b0, 32'h7FFF_FFFC, 32'd0,         4'd0, 0);
    transact("ld_top",   1'b0, 32'h8000_0FFC, 32'd0,         4'd0, 0);

    // A store aborted by reset while busy must leave memory untouched.
    transact("st_pre",   1'b1, 32'h8000_0020, 32'h1122_3344, 4'd4, 0);
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D;
    req_len = 4'd4; req_valid = 1'b1;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    transact("ld_abort", 1'b0, 32'h8000_0020, 32'd0, 4'd0, 0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
